car_motion_ctrl: RTL and testbench
==================================

Name: car_motion_ctrl

Overview:
Responder end of the floor-request interface. It accepts one-hot destination requests from the request/latching logic through a valid/ready handshake and steps the car one floor per step tick toward the destination. It holds the door open for a fixed dwell, then returns an arrival pulse with the served floor so the requester can clear that call. Its outputs drive the floor HEX decoders and the up/down direction LEDs on DE1_SoC.

Parameters:
N_FLOORS, 6, number of floors; one-hot width of all floor buses.
DWELL_TICKS, 3, step ticks the door stays open after arrival (1..15).

Ports:
clk  input  1  system clock (divided clock from clock_divider).
reset  input  1  synchronous, active-high reset.
step_en  input  1  motion/timer tick; when tied to 1, one step per clock.
req_valid  input  1  requester presents a destination.
req_dest  input  N_FLOORS  one-hot destination floor; bit 0 = floor 1.
req_ready  output  1  car can accept a request this cycle.
cur_floor  output  N_FLOORS  one-hot current floor.
moving  output  1  car is between steps (MOVE_UP or MOVE_DOWN).
dir_up  output  1  1 = up, 0 = down; valid only while moving = 1.
door_open  output  1  door open (DOOR state).
arrived  output  1  one-clock pulse on entry to DOOR.
arrived_floor  output  N_FLOORS  one-hot floor served; valid with arrived, 0 otherwise.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset takes priority over every other input, including a reset asserted mid-move or mid-dwell.
- Reset values: state = IDLE, cur_floor = 6'b000001, req_ready = 1, moving = 0, dir_up = 0, door_open = 0, arrived = 0, arrived_floor = 0, dwell counter = 0, target = 0. No pending request survives reset.
- Handshake:
  - A request transfers on a clock edge where req_valid & req_ready & (req_dest != 0).
  - req_ready = 1 only in IDLE.
  - req_dest = 0 is never accepted; the block stays in IDLE.
  - Multi-hot req_dest: the lowest-index set bit is the target.
  - The target is registered at accept. Later changes on req_dest have no effect until the next accept.
- State machine (states IDLE, MOVE_UP, MOVE_DOWN, DOOR; held in a shared enum):
  - IDLE, on accept:
    - target > cur_floor → MOVE_UP.
    - target < cur_floor → MOVE_DOWN.
    - target == cur_floor → DOOR directly, with zero steps.
  - MOVE_UP: on each step_en, cur_floor shifts left by 1. If the new floor equals target → DOOR.
  - MOVE_DOWN: same as MOVE_UP, shifting right.
  - Without step_en, every state holds.
  - DOOR:
    - The dwell counter loads DWELL_TICKS-1 on entry.
    - It decrements on each step_en.
    - At 0 with step_en → IDLE.
    - Door-open time is exactly DWELL_TICKS step ticks.
- Arrival outputs:
  - arrived is high for exactly one clk on the cycle after DOOR is entered, i.e. registered and coincident with door_open first going high.
  - arrived_floor equals cur_floor during that cycle.
- Motion outputs:
  - moving is high exactly in MOVE_UP/MOVE_DOWN.
  - dir_up = 1 in MOVE_UP, 0 otherwise.
  - cur_floor is always exactly one-hot.
- Boundaries:
  - cur_floor never shifts past bit 0 or bit N_FLOORS-1. Hitting the top or bottom bit without matching target is unreachable by construction; an assertion checks it.
  - Latency floor k→j with step_en = 1 every clock: accept edge + |j-k| clocks to reach DOOR; arrived is asserted on the following cycle.
  - A request presented outside IDLE is ignored (not queued). The requester holds it until req_ready.

Decomposition:
- Package elevator_pkg holds:
  - N_FLOORS default constant.
  - car_state_e enum {IDLE, MOVE_UP, MOVE_DOWN, DOOR}.
  - Function onehot_lowest (isolates the lowest set bit) and onehot comparison helpers for greater-than/less-than on one-hot vectors (converted via priority encode to index).
- Sub-module dwell_timer holds the loadable down-counter with step_en and a zero flag.
- The FSM and position register stay in car_motion_ctrl.

Test Plan:
1. Reset, then hold reset mid-move from floor 2→5 → next clock: cur_floor = 000001, IDLE, req_ready = 1, moving = 0, arrived = 0.
2. From floor 1, req_dest = 010000, step_en = 1 → accept, 4 clocks MOVE_UP with dir_up = 1, cur_floor 000010→…→010000. Then one arrived pulse with arrived_floor = 010000, door_open for 3 clocks, then req_ready = 1.
3. At floor 5, req_dest = 000100 → MOVE_DOWN, dir_up = 0, 2 steps to 000100, arrived pulse. Check that step_en low for 5 clocks mid-move freezes cur_floor and the state.
4. At floor 3, req_dest = 000100 (same floor) → no motion (moving stays 0), DOOR entered, arrived with 000100, door_open for DWELL_TICKS ticks.
5. req_dest = 000000 with req_valid = 1 → never accepted, stays IDLE. Then req_dest = 101000 → target 001000 (lowest bit).
6. During MOVE_UP, change req_dest to 000001 with req_valid = 1 → ignored, the original target is served. The new request is accepted only once req_ready = 1 again.

Source files
------------

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared types and one-hot floor helpers for the car motion
//                controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    // Default number of floors; width of every one-hot floor bus.
    localparam int DEF_N_FLOORS = 6;

    // Helpers work on a fixed wide vector so any floor count up to this fits.
    localparam int MAX_FLOORS = 32;
    localparam int IDX_W      = 6;

    typedef logic [MAX_FLOORS-1:0] floor_vec_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } car_state_e;

    // Keep only the lowest set bit (two's-complement trick).
    function automatic floor_vec_t onehot_lowest(input floor_vec_t v);
        return v & (~v + floor_vec_t'(1));
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] onehot_index(input floor_vec_t v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Floor a is above floor b.
    function automatic logic onehot_gt(input floor_vec_t a, input floor_vec_t b);
        return onehot_index(a) > onehot_index(b);
    endfunction

    // Floor a is below floor b.
    function automatic logic onehot_lt(input floor_vec_t a, input floor_vec_t b);
        return onehot_index(a) < onehot_index(b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_timer
//  Description : Loadable down-counter advanced by step ticks, with a zero
//                flag. Used to time how long the car door stays open.
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over counting; the counter parks at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (step_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/car_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : car_motion_ctrl
//  Description : Elevator car controller. Accepts one-hot destination
//                requests via valid/ready, steps the car one floor per step
//                tick, holds the door for a fixed dwell and pulses arrival.
//  Revision    : 1.0 - initial release
// ============================================================================
module car_motion_ctrl
    import elevator_pkg::*;
#(
    parameter int N_FLOORS    = DEF_N_FLOORS,
    parameter int DWELL_TICKS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_en,
    input  logic                req_valid,
    input  logic [N_FLOORS-1:0] req_dest,
    output logic                req_ready,
    output logic [N_FLOORS-1:0] cur_floor,
    output logic                moving,
    output logic                dir_up,
    output logic                door_open,
    output logic                arrived,
    output logic [N_FLOORS-1:0] arrived_floor
);

    localparam int               CNT_W        = 4;
    localparam logic [CNT_W-1:0] C_DWELL_LOAD = CNT_W'(DWELL_TICKS - 1);

    car_state_e          r_state;
    car_state_e          w_next_state;
    logic [N_FLOORS-1:0] r_cur_floor;
    logic [N_FLOORS-1:0] w_next_floor;
    logic [N_FLOORS-1:0] r_target;
    logic [N_FLOORS-1:0] w_next_target;
    logic [N_FLOORS-1:0] w_req_target;
    logic [N_FLOORS-1:0] r_arrived_floor;
    logic                r_arrived;
    logic                w_accept;
    logic                w_enter_door;
    logic                w_dwell_zero;

    // A multi-hot request resolves to its lowest floor.
    assign w_req_target = N_FLOORS'(onehot_lowest(floor_vec_t'(req_dest)));
    assign w_accept     = req_valid && (r_state == IDLE) && (req_dest != '0);

    // Door dwell counter, loaded on every entry into DOOR.
    dwell_timer #(
        .CNT_W    (CNT_W)
    ) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .step_en  (step_en && (r_state == DOOR)),
        .load     (w_enter_door),
        .load_val (C_DWELL_LOAD),
        .zero     (w_dwell_zero)
    );

    // Next-state, next-position and target capture logic.
    always_comb begin
        w_next_state  = r_state;
        w_next_floor  = r_cur_floor;
        w_next_target = r_target;
        w_enter_door  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_target = w_req_target;
                    if (onehot_gt(floor_vec_t'(w_req_target), floor_vec_t'(r_cur_floor))) begin
                        w_next_state = MOVE_UP;
                    end else if (onehot_lt(floor_vec_t'(w_req_target), floor_vec_t'(r_cur_floor))) begin
                        w_next_state = MOVE_DOWN;
                    end else begin
                        w_next_state = DOOR;
                        w_enter_door = 1'b1;
                    end
                end
            end
            MOVE_UP: begin
                if (step_en) begin
                    // Never shift the car off the top floor.
                    if (!r_cur_floor[N_FLOORS-1]) w_next_floor = r_cur_floor << 1;
                    if (w_next_floor == r_target) begin
                        w_next_state = DOOR;
                        w_enter_door = 1'b1;
                    end
                end
            end
            MOVE_DOWN: begin
                if (step_en) begin
                    // Never shift the car off the bottom floor.
                    if (!r_cur_floor[0]) w_next_floor = r_cur_floor >> 1;
                    if (w_next_floor == r_target) begin
                        w_next_state = DOOR;
                        w_enter_door = 1'b1;
                    end
                end
            end
            DOOR: begin
                if (step_en && w_dwell_zero) w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, position, target and registered arrival outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_cur_floor     <= N_FLOORS'(1);
            r_target        <= '0;
            r_arrived       <= 1'b0;
            r_arrived_floor <= '0;
        end else begin
            r_state         <= w_next_state;
            r_cur_floor     <= w_next_floor;
            r_target        <= w_next_target;
            r_arrived       <= w_enter_door;
            r_arrived_floor <= w_enter_door ? w_next_floor : '0;
        end
    end

    assign req_ready     = (r_state == IDLE);
    assign cur_floor     = r_cur_floor;
    assign moving        = (r_state == MOVE_UP) || (r_state == MOVE_DOWN);
    assign dir_up        = (r_state == MOVE_UP);
    assign door_open     = (r_state == DOOR);
    assign arrived       = r_arrived;
    assign arrived_floor = r_arrived_floor;

    // The car must reach its target before running off either end.
    a_no_top_overrun : assert property (@(posedge clk) disable iff (reset)
        (r_state == MOVE_UP) |-> !r_cur_floor[N_FLOORS-1]);
    a_no_bottom_overrun : assert property (@(posedge clk) disable iff (reset)
        (r_state == MOVE_DOWN) |-> !r_cur_floor[0]);
    a_floor_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot(r_cur_floor));

endmodule
`default_nettype wire

// File: tb/tb_car_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_car_motion_ctrl
//  Description : Directed, table-driven self-checking bench for
//                car_motion_ctrl (6 floors, 3-tick dwell).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_car_motion_ctrl;

    logic       clk;
    logic       reset;
    logic       step_en;
    logic       req_valid;
    logic [5:0] req_dest;
    logic       req_ready;
    logic [5:0] cur_floor;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic       arrived;
    logic [5:0] arrived_floor;

    int checks   = 0;
    int failures = 0;

    car_motion_ctrl #(
        .N_FLOORS      (6),
        .DWELL_TICKS   (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .step_en       (step_en),
        .req_valid     (req_valid),
        .req_dest      (req_dest),
        .req_ready     (req_ready),
        .cur_floor     (cur_floor),
        .moving        (moving),
        .dir_up        (dir_up),
        .door_open     (door_open),
        .arrived       (arrived),
        .arrived_floor (arrived_floor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus and the outputs expected just after that edge.
    typedef struct {
        logic       rst;
        logic       step;
        logic       valid;
        logic [5:0] dest;
        logic [5:0] cur;
        logic       rdy;
        logic       mov;
        logic       up;
        logic       door;
        logic       arr;
        logic [5:0] af;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic rst, input logic step, input logic valid,
                     input logic [5:0] dest, input logic [5:0] cur,
                     input logic rdy, input logic mov, input logic up,
                     input logic door, input logic arr, input logic [5:0] af);
        vec_t e;
        e.rst = rst; e.step = step; e.valid = valid; e.dest = dest;
        e.cur = cur; e.rdy = rdy; e.mov = mov; e.up = up;
        e.door = door; e.arr = arr; e.af = af;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    int lat;
    int dcnt;

    initial begin
        reset = 1'b1; step_en = 1'b0; req_valid = 1'b0; req_dest = '0;

        // Reset state, and reset outranking a request.
        v(1,0,0,6'b000000, 6'b000001,1,0,0,0,0,6'b0);
        v(1,1,1,6'b010000, 6'b000001,1,0,0,0,0,6'b0);
        // Floor 1 -> 5: four up steps, arrival, three-tick dwell.
        v(0,1,1,6'b010000, 6'b000001,0,1,1,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b000010,0,1,1,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b000100,0,1,1,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b001000,0,1,1,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b010000,0,0,0,1,1,6'b010000);
        v(0,1,0,6'b000000, 6'b010000,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b010000,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b010000,1,0,0,0,0,6'b0);
        // Floor 5 -> 3 with step_en held low for 5 clocks mid-move.
        v(0,1,1,6'b000100, 6'b010000,0,1,0,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b001000,0,1,0,0,0,6'b0);
        for (int i = 0; i < 5; i++) v(0,0,0,6'b000000, 6'b001000,0,1,0,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b000100,0,0,0,1,1,6'b000100);
        v(0,1,0,6'b000000, 6'b000100,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b000100,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b000100,1,0,0,0,0,6'b0);
        // Same-floor request: straight to DOOR; a missing tick stretches the dwell.
        v(0,1,1,6'b000100, 6'b000100,0,0,0,1,1,6'b000100);
        v(0,0,0,6'b000000, 6'b000100,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b000100,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b000100,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b000100,1,0,0,0,0,6'b0);
        // Empty request refused; multi-hot resolves to lowest bit (floor 4).
        v(0,1,1,6'b000000, 6'b000100,1,0,0,0,0,6'b0);
        v(0,1,1,6'b000000, 6'b000100,1,0,0,0,0,6'b0);
        v(0,1,1,6'b101000, 6'b000100,0,1,1,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b001000,0,0,0,1,1,6'b001000);
        v(0,1,0,6'b000000, 6'b001000,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b001000,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b001000,1,0,0,0,0,6'b0);
        // Floor 4 -> 6; a new request mid-move is ignored until ready again.
        v(0,1,1,6'b100000, 6'b001000,0,1,1,0,0,6'b0);
        v(0,1,1,6'b000001, 6'b010000,0,1,1,0,0,6'b0);
        v(0,1,1,6'b000001, 6'b100000,0,0,0,1,1,6'b100000);
        v(0,1,1,6'b000001, 6'b100000,0,0,0,1,0,6'b0);
        v(0,1,1,6'b000001, 6'b100000,0,0,0,1,0,6'b0);
        v(0,1,1,6'b000001, 6'b100000,1,0,0,0,0,6'b0);
        v(0,1,1,6'b000001, 6'b100000,0,1,0,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b010000,0,1,0,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b001000,0,1,0,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b000100,0,1,0,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b000010,0,1,0,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b000001,0,0,0,1,1,6'b000001);
        v(0,1,0,6'b000000, 6'b000001,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b000001,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b000001,1,0,0,0,0,6'b0);
        // Floor 1 -> 2, then 2 -> 5 interrupted by reset mid-move.
        v(0,1,1,6'b000010, 6'b000001,0,1,1,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b000010,0,0,0,1,1,6'b000010);
        v(0,1,0,6'b000000, 6'b000010,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b000010,0,0,0,1,0,6'b0);
        v(0,1,0,6'b000000, 6'b000010,1,0,0,0,0,6'b0);
        v(0,1,1,6'b010000, 6'b000010,0,1,1,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b000100,0,1,1,0,0,6'b0);
        v(1,1,1,6'b010000, 6'b000001,1,0,0,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b000001,1,0,0,0,0,6'b0);
        // Reset during the dwell.
        v(0,1,1,6'b000001, 6'b000001,0,0,0,1,1,6'b000001);
        v(1,1,0,6'b000000, 6'b000001,1,0,0,0,0,6'b0);
        v(0,1,0,6'b000000, 6'b000001,1,0,0,0,0,6'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset     = vecs[i].rst;
            step_en   = vecs[i].step;
            req_valid = vecs[i].valid;
            req_dest  = vecs[i].dest;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  32'({cur_floor, req_ready, moving, dir_up, door_open, arrived, arrived_floor}),
                  32'({vecs[i].cur, vecs[i].rdy, vecs[i].mov, vecs[i].up,
                       vecs[i].door, vecs[i].arr, vecs[i].af}));
        end

        // Latency 1 -> 6 with continuous ticks: arrival visible after accept + 5 clocks.
        @(negedge clk);
        reset = 1'b0; step_en = 1'b1; req_valid = 1'b1; req_dest = 6'b100000;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            req_dest  = '0;
            if (arrived) begin
                lat = i;
                break;
            end
        end
        check("latency_1to6", 32'(lat), 32'd6);
        check("arr_floor_6", 32'(arrived_floor), 32'h20);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!door_open) break;
            dcnt++;
            @(posedge clk);
            #1;
        end
        check("dwell_len", 32'(dcnt), 32'd3);
        check("ready_after", 32'({req_ready, arrived, cur_floor}), 32'({1'b1, 1'b0, 6'b100000}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
